score_bcd_converter: RTL and testbench

- Sequential, parametrised binary-to-BCD converter (shift-add-3 / double dabble) for score and house-point displays.
- Converts a BIN_W-bit unsigned score into DIGITS BCD digits, one bit per clock, with a start/ready/done handshake.
- Adds a leaderboard hold (freeze) mode, leading-zero blanking and overflow saturation.
- Sits between the score accumulator and the seven-segment/VGA digit renderer.

---
 rtl/score_bcd_converter_pkg.sv | 32 +++
 rtl/score_bcd_converter_digit_adj.sv | 16 +
 rtl/score_bcd_converter.sv | 158 +++++++++++++++
 tb/tb_score_bcd_converter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_bcd_converter_pkg.sv
// Shared constants, FSM state type and leading-zero helper for the score BCD converter.
package score_pkg;

    localparam int         DIGIT_W        = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADD3           = 4'd3;
    // Upper bound on DIGITS supported by digit_blank.
    localparam int         MAX_DIGITS     = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Digit idx is blank when idx>0 and every digit from idx up to the top is zero.
    function automatic logic digit_blank(
        input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
        input int                            idx,
        input int                            digits
    );
        logic any_nz;
        any_nz = 1'b0;
        for (int i = 1; i < MAX_DIGITS; i++) begin
            if (i >= idx && i < digits && bcd[i*DIGIT_W +: DIGIT_W] != '0) begin
                any_nz = 1'b1;
            end
        end
        return (idx != 0) && !any_nz;
    endfunction

endpackage

// File: rtl/score_bcd_converter_digit_adj.sv
// One double-dabble correction: a digit of 5 or more gets 3 added (4-bit, no carry out).
module bcd_digit_adj
    import score_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_out = digit_in + ADD3;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter, one bit per clock, with display hold,
// leading-zero blanking and saturation to all nines on overflow.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int BIN_W  = 25,
    parameter int DIGITS = 8,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    input  logic                      hold,
    output logic                      ready,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]         blank,
    output logic                      overflow
);

    localparam int                ACC_W     = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               overflow_q, overflow_d;
    logic [ACC_W-1:0]   pend_bcd_q, pend_bcd_d;
    logic [DIGITS-1:0]  pend_blank_q, pend_blank_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               pend_valid_q, pend_valid_d;

    logic [ACC_W-1:0]              acc_adj;
    logic                          wr_res;
    logic [ACC_W-1:0]              res_bcd;
    logic [DIGITS-1:0]             res_blank;
    logic [DIGIT_W*MAX_DIGITS-1:0] res_ext;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            bcd_q        <= '0;
            blank_q      <= BLANK_RST;
            overflow_q   <= 1'b0;
            pend_bcd_q   <= '0;
            pend_blank_q <= BLANK_RST;
            pend_ovf_q   <= 1'b0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            bcd_q        <= bcd_d;
            blank_q      <= blank_d;
            overflow_q   <= overflow_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_blank_q <= pend_blank_d;
            pend_ovf_q   <= pend_ovf_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        wr_res  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A bit leaving the top digit means the value needs more digits than we have.
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                ovf_d         = ovf_q | acc_adj[ACC_W-1];
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    wr_res  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_bcd = ovf_d ? {DIGITS{4'h9}} : acc_d;
        res_ext = '0;
        res_ext[ACC_W-1:0] = res_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            res_blank[i] = digit_blank(res_ext, i, DIGITS);
        end
    end

    // A fresh result written with hold low wins over any pending one.
    always_comb begin
        bcd_d        = bcd_q;
        blank_d      = blank_q;
        overflow_d   = overflow_q;
        pend_bcd_d   = pend_bcd_q;
        pend_blank_d = pend_blank_q;
        pend_ovf_d   = pend_ovf_q;
        pend_valid_d = pend_valid_q;
        if (wr_res) begin
            if (!hold) begin
                bcd_d        = res_bcd;
                blank_d      = res_blank;
                overflow_d   = ovf_d;
                pend_valid_d = 1'b0;
            end else begin
                pend_bcd_d   = res_bcd;
                pend_blank_d = res_blank;
                pend_ovf_d   = ovf_d;
                pend_valid_d = 1'b1;
            end
        end else if (!hold && pend_valid_q) begin
            bcd_d        = pend_bcd_q;
            blank_d      = pend_blank_q;
            overflow_d   = pend_ovf_q;
            pend_valid_d = 1'b0;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench: default 25-bit/8-digit converter plus a 10-bit/3-digit one for overflow.
module tb_score_bcd_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  blank;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic        rst0, start0, hold0, rdy0, done0, ovf0;
    logic [24:0] bin0;
    logic [31:0] bcd0;
    logic [7:0]  blank0;

    logic        rst1, start1, hold1, rdy1, done1, ovf1;
    logic [9:0]  bin1;
    logic [11:0] bcd1;
    logic [2:0]  blank1;

    score_bcd_converter u_dut0 (
        .clk      (clk),
        .resetn   (rst0),
        .start    (start0),
        .bin_in   (bin0),
        .hold     (hold0),
        .ready    (rdy0),
        .done     (done0),
        .bcd      (bcd0),
        .blank    (blank0),
        .overflow (ovf0)
    );

    score_bcd_converter #(.BIN_W(10), .DIGITS(3)) u_dut1 (
        .clk      (clk),
        .resetn   (rst1),
        .start    (start1),
        .bin_in   (bin1),
        .hold     (hold1),
        .ready    (rdy1),
        .done     (done1),
        .bcd      (bcd1),
        .blank    (blank1),
        .overflow (ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_done", 32'(done0), 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("d0_latency", cyc, e0.cyc);
                chk("d0_bcd", bcd0, e0.bcd);
                chk("d0_blank", {24'b0, blank0}, {24'b0, e0.blank});
                chk("d0_overflow", {31'b0, ovf0}, {31'b0, e0.ovf});
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("d1_latency", cyc, e1.cyc);
                chk("d1_bcd", {20'b0, bcd1}, e1.bcd);
                chk("d1_blank", {29'b0, blank1}, {24'b0, e1.blank});
                chk("d1_overflow", {31'b0, ovf1}, {31'b0, e1.ovf});
            end
        end
    end

    // Issue one conversion on DUT d; push the expected visible outputs at done when push=1.
    task automatic issue(input int d, input logic [24:0] v, input bit push,
                         input logic [31:0] eb, input logic [7:0] ebl, input logic eo);
        int   t;
        exp_t e;
        t = 0;
        while (((d == 0) ? rdy0 : rdy1) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(d == 0 ? rdy0 : rdy1), 32'd1);
        @(negedge clk);
        if (d == 0) begin start0 = 1'b1; bin0 = v; end
        else begin start1 = 1'b1; bin1 = v[9:0]; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        bin0   = 25'h0AAAAAA;
        bin1   = 10'h155;
        if (push) begin
            e.bcd   = eb;
            e.blank = ebl;
            e.ovf   = eo;
            e.cyc   = cyc + ((d == 0) ? 25 : 10);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((d == 0) ? done0 : done1) !== 1'b1 && t < 60);
        if (t >= 60) chk("done_timeout", 32'(d == 0 ? done0 : done1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b0; start0 = 1'b0; hold0 = 1'b0; bin0 = '0;
        rst1 = 1'b0; start1 = 1'b0; hold1 = 1'b0; bin1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;

        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_bcd", bcd0, 32'h0);
        chk("rst_blank", 32'(blank0), 32'hFE);
        chk("rst_overflow", 32'(ovf0), 32'd0);

        // Abort a conversion with reset at edge 10; no done may follow.
        issue(0, 25'd12345, 1'b0, 32'h0, 8'h0, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst0 = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy0), 32'd1);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_bcd", bcd0, 32'h0);
        chk("abort_blank", 32'(blank0), 32'hFE);
        @(negedge clk);
        rst0 = 1'b1;
        repeat (40) @(posedge clk);

        issue(0, 25'd12345, 1'b1, 32'h0001_2345, 8'hE0, 1'b0);
        wait_done(0);
        issue(0, 25'd0, 1'b1, 32'h0, 8'hFE, 1'b0);
        wait_done(0);

        // Max input, with a start pulse during SHIFT that must be ignored.
        issue(0, 25'h1FFFFFF, 1'b1, 32'h3355_4431, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        bin0   = 25'd5;
        @(negedge clk);
        start0 = 1'b0;
        chk("shift_ready_low", 32'(rdy0), 32'd0);
        wait_done(0);
        chk("done_ready_low", 32'(rdy0), 32'd0);
        @(negedge clk);
        chk("ready_after_done", 32'(rdy0), 32'd1);
        chk("done_one_cycle", 32'(done0), 32'd0);

        // Hold: two results done while the display keeps the max value.
        @(negedge clk);
        hold0 = 1'b1;
        issue(0, 25'd42, 1'b1, 32'h3355_4431, 8'h00, 1'b0);
        wait_done(0);
        issue(0, 25'd77, 1'b1, 32'h3355_4431, 8'h00, 1'b0);
        wait_done(0);
        @(negedge clk);
        chk("hold_still", bcd0, 32'h3355_4431);
        hold0 = 1'b0;
        @(posedge clk);
        #1;
        chk("release_bcd", bcd0, 32'h77);
        chk("release_blank", 32'(blank0), 32'hFC);
        chk("release_overflow", 32'(ovf0), 32'd0);

        // Hold release coincides with the write of 500 while 42 is pending.
        @(negedge clk);
        hold0 = 1'b1;
        issue(0, 25'd42, 1'b1, 32'h77, 8'hFC, 1'b0);
        wait_done(0);
        issue(0, 25'd500, 1'b1, 32'h500, 8'hF8, 1'b0);
        repeat (24) @(posedge clk);
        @(negedge clk);
        hold0 = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("pending_cleared", bcd0, 32'h500);

        // Small instance: saturation and recovery.
        issue(1, 25'd1000, 1'b1, 32'h999, 8'h0, 1'b1);
        wait_done(1);
        issue(1, 25'd7, 1'b1, 32'h007, 8'h06, 1'b0);
        wait_done(1);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
